// File: rtl/ir_pkg.sv
// Shared definitions for the IR key pulser: FSM state encoding and a
// constant-evaluable ceil(log2) helper used for key index widths.
package ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_DELAY,
    ST_PULSE,
    ST_GAP,
    ST_HOLD
  } state_t;

  function automatic int ir_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ir_prio_enc.sv
// Combinational priority encoder: index of the lowest set request bit.
module ir_prio_enc
  import ir_pkg::*;
#(
  parameter int NCH = 16,
  parameter int KW  = 4
) (
  input  logic [NCH-1:0] req,
  output logic [KW-1:0]  idx,
  output logic           valid
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx   = KW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ir_key_pulser.sv
// Key scanner for an IR remote: synchronise, debounce, delay, then emit
// fixed-width drive pulses (optionally auto-repeating) for the lowest key.
module ir_key_pulser
  import ir_pkg::*;
#(
  parameter int NCH        = 16,
  parameter int DEBOUNCE   = 2500,
  parameter int FIRST_DLY  = 2500,
  parameter int REPEAT_DLY = 0,
  parameter int PW         = 1,
  parameter int CW         = 24
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            push,
  output logic                      pulse,
  output logic [ir_clog2(NCH)-1:0]  key_code,
  output logic                      busy
);

  localparam int KW = ir_clog2(NCH);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] DLY_LAST = CW'(FIRST_DLY - 1);
  localparam logic [CW-1:0] PW_LAST  = CW'(PW - 1);
  localparam logic [CW-1:0] REP_LAST = CW'((REPEAT_DLY > 0) ? REPEAT_DLY - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_DLY != 0);

  logic [NCH-1:0] sync1_q;
  logic [NCH-1:0] sp_q;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [KW-1:0]  code_q, code_d;
  logic           pulse_q, pulse_d;
  logic [KW-1:0]  low_idx;
  logic           low_vld;
  logic           held;

  ir_prio_enc #(
    .NCH (NCH),
    .KW  (KW)
  ) u_prio (
    .req   (sp_q),
    .idx   (low_idx),
    .valid (low_vld)
  );

  // A key counts as held only while it is still the lowest one pressed.
  assign held = low_vld && (low_idx == code_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sp_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      code_q  <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= push;
      sp_q    <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      ST_IDLE: begin
        if (low_vld) begin
          state_d = ST_DEBOUNCE;
          code_d  = low_idx;
        end
      end
      ST_DEBOUNCE: begin
        if (!held)                  state_d = ST_IDLE;
        else if (cnt_q == DEB_LAST) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (!held)                  state_d = ST_IDLE;
        else if (cnt_q == DLY_LAST) state_d = ST_PULSE;
      end
      // Pulse width is fixed; the key is only looked at on the last cycle.
      ST_PULSE: begin
        if (cnt_q == PW_LAST) begin
          if (!held)          state_d = ST_IDLE;
          else if (REPEAT_EN) state_d = ST_GAP;
          else                state_d = ST_HOLD;
        end
      end
      ST_GAP: begin
        if (!held)                  state_d = ST_IDLE;
        else if (cnt_q == REP_LAST) state_d = ST_PULSE;
      end
      ST_HOLD: begin
        if (!held) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_d != state_q) || (state_q == ST_IDLE) || (state_q == ST_HOLD))
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;

    pulse_d = (state_d == ST_PULSE);
  end

  assign pulse    = pulse_q;
  assign key_code = code_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ir_key_pulser.sv
// Scoreboard bench: two pulser instances (auto-repeat on / off) share one
// push bus; expected pulses come from an interval model of the key timeline.
module tb_ir_key_pulser;

  localparam int NCH = 4;
  localparam int DEB = 4;
  localparam int FD  = 10;
  localparam int PW  = 2;
  localparam int RD  = 20;
  localparam int CW  = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] push;
  logic       pulse_a, pulse_b, busy_a, busy_b;
  logic [1:0] code_a, code_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Expected pulse entries: rising-edge cycle * 16 + key code.
  int         exp_a[$];
  int         exp_b[$];
  logic [3:0] seg_pat[$];
  int         seg_len[$];

  bit in_p[2];
  int width[2];
  int cur_code[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ir_key_pulser #(
    .NCH(NCH), .DEBOUNCE(DEB), .FIRST_DLY(FD), .REPEAT_DLY(RD), .PW(PW), .CW(CW)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .push(push),
    .pulse(pulse_a), .key_code(code_a), .busy(busy_a)
  );

  ir_key_pulser #(
    .NCH(NCH), .DEBOUNCE(DEB), .FIRST_DLY(FD), .REPEAT_DLY(0), .PW(PW), .CW(CW)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .push(push),
    .pulse(pulse_b), .key_code(code_b), .busy(busy_b)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end else begin
      $display("ok   %s at cycle %0d: %0d", name, cyc, act);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int b = 0; b < 4; b++) if (v[b]) return b;
    return -1;
  endfunction

  task automatic mon(input int i, input logic p, input logic [1:0] c);
    int ent;
    bit have;
    ent  = 0;
    have = 0;
    if (!rst_n) begin
      in_p[i]  = 0;
      width[i] = 0;
      return;
    end
    if (p && !in_p[i]) begin
      if (i == 0 && exp_a.size() > 0) begin ent = exp_a.pop_front(); have = 1; end
      if (i == 1 && exp_b.size() > 0) begin ent = exp_b.pop_front(); have = 1; end
      if (!have) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse inst%0d: rose at cycle %0d code %0d, expected no pulse",
                 i, cyc, c);
      end else begin
        chk($sformatf("pulse_start_inst%0d", i), cyc, ent / 16);
        chk($sformatf("pulse_code_inst%0d", i), int'(c), ent % 16);
      end
      in_p[i]     = 1;
      width[i]    = 1;
      cur_code[i] = int'(c);
    end else if (p) begin
      width[i]++;
      chk($sformatf("code_stable_inst%0d", i), int'(c), cur_code[i]);
    end else if (in_p[i]) begin
      chk($sformatf("pulse_width_inst%0d", i), width[i], PW);
      in_p[i] = 0;
    end
  endtask

  always @(negedge clk) begin
    mon(0, pulse_a, code_a);
    mon(1, pulse_b, code_b);
  end

  // Each run of constant lowest key is visible to the FSM on edges
  // [start+3, end+2]; capture waits until the previous run has finished.
  task automatic model_run(input int e_start);
    int s, j, k, tot, a, b, c, h, p, r, rdv;
    int free_t[2];
    free_t[0] = 0;
    free_t[1] = 0;
    s = e_start;
    j = 0;
    while (j < seg_pat.size()) begin
      k   = lowest(seg_pat[j]);
      tot = seg_len[j];
      j++;
      while (j < seg_pat.size() && lowest(seg_pat[j]) == k) begin
        tot += seg_len[j];
        j++;
      end
      if (k >= 0) begin
        a = s + 3;
        b = s + tot + 2;
        for (int i = 0; i < 2; i++) begin
          rdv = (i == 0) ? RD : 0;
          c   = (a > free_t[i]) ? a : free_t[i];
          if (c <= b) begin
            h = b;
            r = h + 1;
            p = c + DEB + FD;
            while (p <= h) begin
              if (i == 0) exp_a.push_back(p * 16 + k);
              else        exp_b.push_back(p * 16 + k);
              if (r > p && r < p + PW) r = p + PW;
              if (rdv == 0) break;
              p += PW + rdv;
            end
            free_t[i] = r + 1;
          end
        end
      end
      s += tot;
    end
  endtask

  task automatic drive_segments();
    int e0;
    @(posedge clk);
    #1;
    e0 = cyc;
    model_run(e0);
    for (int j = 0; j < seg_pat.size(); j++) begin
      push = seg_pat[j];
      repeat (seg_len[j]) @(posedge clk);
      #1;
    end
    push = '0;
    seg_pat.delete();
    seg_len.delete();
  endtask

  task automatic add_seg(input logic [3:0] p, input int l);
    seg_pat.push_back(p);
    seg_len.push_back(l);
  endtask

  initial begin
    int e0;
    int waited;
    rst_n = 1'b0;
    push  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pulse_a", int'(pulse_a), 0);
    chk("reset_pulse_b", int'(pulse_b), 0);
    chk("reset_busy_a", int'(busy_a), 0);
    chk("reset_busy_b", int'(busy_b), 0);
    chk("reset_code_a", int'(code_a), 0);
    chk("reset_code_b", int'(code_b), 0);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Key 2 held 100 cycles: repeat pulses at 17,39,61,83; single pulse at 17.
    @(posedge clk);
    #1;
    e0   = cyc;
    push = 4'b0100;
    exp_a.push_back((e0 + 17) * 16 + 2);
    exp_a.push_back((e0 + 39) * 16 + 2);
    exp_a.push_back((e0 + 61) * 16 + 2);
    exp_a.push_back((e0 + 83) * 16 + 2);
    exp_b.push_back((e0 + 17) * 16 + 2);
    repeat (50) @(posedge clk);
    #1;
    chk("held_busy_b", int'(busy_b), 1);
    chk("held_code_b", int'(code_b), 2);
    repeat (50) @(posedge clk);
    #1;
    push = '0;
    repeat (40) @(posedge clk);
    #1;
    chk("held_done_busy_a", int'(busy_a), 0);
    chk("held_done_busy_b", int'(busy_b), 0);
    chk("held_drain_a", exp_a.size(), 0);
    chk("held_drain_b", exp_b.size(), 0);

    // Three-cycle glitch on key 0: debounce starts, then falls back to idle.
    @(posedge clk);
    #1;
    push = 4'b0001;
    repeat (3) @(posedge clk);
    #1;
    push = '0;
    @(posedge clk);
    #1;
    chk("glitch_busy_a", int'(busy_a), 1);
    repeat (10) @(posedge clk);
    #1;
    chk("glitch_idle_a", int'(busy_a), 0);
    chk("glitch_idle_b", int'(busy_b), 0);

    // Two keys, drop the lower mid-gap, release during a pulse, short glitch.
    add_seg(4'b1010, 50);
    add_seg(4'b1000, 60);
    add_seg(4'b0000, 40);
    add_seg(4'b0100, 15);
    add_seg(4'b0000, 30);
    add_seg(4'b0010, 3);
    add_seg(4'b0000, 30);
    drive_segments();

    // Randomised press/release timeline.
    for (int n = 0; n < 40; n++) begin
      logic [3:0] p;
      int         l;
      p = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      l = ($urandom_range(0, 3) == 0) ? int'($urandom_range(30, 110))
                                      : int'($urandom_range(3, 30));
      add_seg(p, l);
    end
    add_seg(4'b0000, 40);
    drive_segments();
    chk("random_drain_a", exp_a.size(), 0);
    chk("random_drain_b", exp_b.size(), 0);

    // Asynchronous reset in the middle of a pulse.
    @(posedge clk);
    #1;
    e0   = cyc;
    push = 4'b0100;
    exp_a.push_back((e0 + 17) * 16 + 2);
    exp_b.push_back((e0 + 17) * 16 + 2);
    waited = 0;
    while (!pulse_a && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("rst_wait_pulse_a", int'(pulse_a), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_a", int'(pulse_a), 0);
    chk("rst_pulse_b", int'(pulse_b), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_code_a", int'(code_a), 0);
    chk("rst_code_b", int'(code_b), 0);
    push = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("post_rst_busy_a", int'(busy_a), 0);
    chk("post_rst_pulse_a", int'(pulse_a), 0);
    chk("final_drain_a", exp_a.size(), 0);
    chk("final_drain_b", exp_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
